// File: rtl/ltc2308_scan_ctrl.sv
// ltc2308_scan_ctrl
// Serial master for the LTC2308 8-channel 12-bit ADC. Scans the channels
// enabled in ch_mask and reports each result as a one-cycle strobe.
// Each frame runs CONVST high, conversion wait, 12 SCK periods, then DONE.
// The LTC2308 applies a config word to the following conversion. So the data
// read in a frame belongs to the channel configured in the previous frame.
//
// Output strobe: sample_valid is a pure one-cycle valid with no ready.
// sample_channel/sample_data are meaningful in the cycle sample_valid is high.
// They then hold until the next strobe. The consumer must take the result in
// that cycle.
module ltc2308_scan_ctrl #(
    parameter int SCK_DIV       = 2,
    parameter int CONVST_CYCLES = 3,
    parameter int CONV_CYCLES   = 80
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic        sample_valid,
    output logic [2:0]  sample_channel,
    output logic [11:0] sample_data,
    output logic        busy,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONVST_HI = 3'd1,
        S_CONV_WAIT = 3'd2,
        S_SHIFT     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // Terminal counts for the shared cycle counter
    localparam logic [15:0] L_CONVST_LAST = 16'(CONVST_CYCLES - 1);
    localparam logic [15:0] L_CONV_LAST   = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] L_SCK_RISE    = 16'(SCK_DIV - 1);
    localparam logic [15:0] L_SCK_LAST    = 16'(2 * SCK_DIV - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_bit_cnt;
    logic [2:0]  r_cfg_ch;
    logic [2:0]  r_last_ch;
    logic [2:0]  r_prev_ch;
    logic        r_prev_valid;
    logic [5:0]  r_cfg_sr;
    logic [11:0] r_shift;
    logic        r_convst;
    logic        r_sck;
    logic        r_sdi;
    logic        r_sample_valid;
    logic [2:0]  r_sample_channel;
    logic [11:0] r_sample_data;
    logic        r_busy;

    logic        w_go;
    logic [2:0]  w_next_from_last;
    logic [2:0]  w_next_from_cfg;
    logic [5:0]  w_cfg_word;

    // Find the lowest set mask bit strictly above 'from', wrapping modulo 8.
    // For a single-bit mask the search wraps back onto the same channel.
    function automatic logic [2:0] f_next_ch(input logic [7:0] mask, input logic [2:0] from);
        logic [2:0] v_res;
        logic [2:0] v_idx;
        logic       v_found;
        v_res   = from;
        v_found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            v_idx = from + 3'(i);
            if (!v_found && mask[v_idx]) begin
                v_res   = v_idx;
                v_found = 1'b1;
            end
        end
        return v_res;
    endfunction

    assign w_go             = enable && (ch_mask != 8'd0);
    assign w_next_from_last = f_next_ch(ch_mask, r_last_ch);
    // In DONE, last_ch takes the value of cfg_ch, so search from cfg_ch.
    assign w_next_from_cfg  = f_next_ch(ch_mask, r_cfg_ch);
    // Config word bits, MSB first: S/D=1, O/S, S1, S0, UNI=1, SLP=0.
    assign w_cfg_word       = {1'b1, r_cfg_ch[0], r_cfg_ch[2], r_cfg_ch[1], 1'b1, 1'b0};

    // Scan sequencer: frame timing, SCK generation, SDI/SDO shifting and result strobe
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state          <= S_IDLE;
            r_cnt            <= 16'd0;
            r_bit_cnt        <= 4'd0;
            r_cfg_ch         <= 3'd0;
            r_last_ch        <= 3'd7;
            r_prev_ch        <= 3'd0;
            r_prev_valid     <= 1'b0;
            r_cfg_sr         <= 6'd0;
            r_shift          <= 12'd0;
            r_convst         <= 1'b0;
            r_sck            <= 1'b0;
            r_sdi            <= 1'b0;
            r_sample_valid   <= 1'b0;
            r_sample_channel <= 3'd0;
            r_sample_data    <= 12'd0;
            r_busy           <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_cfg_ch <= w_next_from_last;
                        r_state  <= S_CONVST_HI;
                        r_convst <= 1'b1;
                        r_busy   <= 1'b1;
                        r_cnt    <= 16'd0;
                    end
                end
                S_CONVST_HI: begin
                    if (r_cnt == L_CONVST_LAST) begin
                        r_state  <= S_CONV_WAIT;
                        r_convst <= 1'b0;
                        r_cnt    <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_CONV_WAIT: begin
                    if (r_cnt == L_CONV_LAST) begin
                        // The first config bit goes out with SCK low.
                        r_state   <= S_SHIFT;
                        r_cnt     <= 16'd0;
                        r_bit_cnt <= 4'd0;
                        r_cfg_sr  <= w_cfg_word;
                        r_sdi     <= w_cfg_word[5];
                        r_sck     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_SHIFT: begin
                    // Sample SDO on the same clk edge that raises SCK.
                    if (r_cnt == L_SCK_RISE) begin
                        r_sck   <= 1'b1;
                        r_shift <= {r_shift[10:0], adc_sdo};
                    end
                    if (r_cnt == L_SCK_LAST) begin
                        r_cnt <= 16'd0;
                        r_sck <= 1'b0;
                        if (r_bit_cnt == 4'd11) begin
                            r_state        <= S_DONE;
                            r_sdi          <= 1'b0;
                            r_sample_valid <= r_prev_valid;
                            if (r_prev_valid) begin
                                r_sample_channel <= r_prev_ch;
                                r_sample_data    <= r_shift;
                            end
                        end else begin
                            // SDI advances on the edge that drops SCK.
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_cfg_sr  <= {r_cfg_sr[4:0], 1'b0};
                            r_sdi     <= r_cfg_sr[4];
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    r_prev_ch    <= r_cfg_ch;
                    r_prev_valid <= 1'b1;
                    r_last_ch    <= r_cfg_ch;
                    if (w_go) begin
                        r_cfg_ch <= w_next_from_cfg;
                        r_state  <= S_CONVST_HI;
                        r_convst <= 1'b1;
                        r_cnt    <= 16'd0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_convst <= 1'b0;
                    r_sck    <= 1'b0;
                    r_sdi    <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign adc_convst     = r_convst;
    assign adc_sck        = r_sck;
    assign adc_sdi        = r_sdi;
    assign sample_valid   = r_sample_valid;
    assign sample_channel = r_sample_channel;
    assign sample_data    = r_sample_data;
    assign busy           = r_busy;
    assign o_dbg_state    = r_state;

endmodule
